// File: rtl/jit_vec_pkg.sv
// Shared types and widths for the vector-pipeline sink: one 25-bit sample
// entry laid out as {tag, data[15:0], lo8[7:0]}.
package jit_vec_pkg;

    localparam int JIT_VEC_BUS_W  = 25;
    localparam int JIT_VEC_DATA_W = 16;
    localparam int JIT_VEC_LO_W   = 8;

    typedef struct packed {
        logic                      tag;
        logic [JIT_VEC_DATA_W-1:0] data;
        logic [JIT_VEC_LO_W-1:0]   lo8;
    } jit_vec_bus_t;

endpackage

// File: rtl/jit_vec_sink_if.sv
// Sample input and valid/ready output bundle of the vector sink.
// master = upstream pipeline plus downstream consumer side, slave = sink.
interface jit_vec_sink_if;
    import jit_vec_pkg::*;

    logic                      in_valid;
    logic                      tag;
    logic [JIT_VEC_DATA_W-1:0] data;
    logic [JIT_VEC_LO_W-1:0]   lo8;

    logic                      out_valid;
    logic                      out_ready;
    logic                      out_tag;
    logic [JIT_VEC_DATA_W-1:0] out_data;
    logic [JIT_VEC_LO_W-1:0]   out_lo8;

    modport master (
        output in_valid, tag, data, lo8, out_ready,
        input  out_valid, out_tag, out_data, out_lo8
    );

    modport slave (
        input  in_valid, tag, data, lo8, out_ready,
        output out_valid, out_tag, out_data, out_lo8
    );

endinterface

// File: rtl/jit_vec_fifo.sv
// DEPTH-entry FIFO of jit_vec_bus_t. A push into a full FIFO is still
// accepted when the head is popped in the same cycle.
module jit_vec_fifo
    import jit_vec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  jit_vec_bus_t               wr_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output jit_vec_bus_t               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       push,
    output logic                       pop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    jit_vec_bus_t  mem_q [DEPTH];
    jit_vec_bus_t  mem_d [DEPTH];
    logic          empty;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        pop   = !empty && rd_ready;
        push  = wr_valid && (!full || pop);

        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/jit_vec_sink.sv
// Buffering sink for the non-stallable vector pipeline, with drop/tag statistics.
// Define JIT_VEC_SINK_CKSUM_EN to add the running-XOR data checksum output cksum.
module jit_vec_sink
    import jit_vec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    jit_vec_sink_if.slave          bus,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [CNT_W-1:0]       tag_cnt,
    output logic                   lo8_err
`ifdef JIT_VEC_SINK_CKSUM_EN
    ,
    output logic [JIT_VEC_DATA_W-1:0] cksum
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    jit_vec_bus_t wr_data;
    jit_vec_bus_t rd_data;
    logic         rd_valid;
    logic         full;
    logic         push;
    logic         pop;
    logic         drop;

    logic             overflow_q, overflow_d;
    logic             lo8_err_q, lo8_err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] tag_cnt_q, tag_cnt_d;

    always_comb begin
        wr_data.tag  = bus.tag;
        wr_data.data = bus.data;
        wr_data.lo8  = bus.lo8;
    end

    jit_vec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst),
        .wr_valid (bus.in_valid),
        .wr_data  (wr_data),
        .rd_ready (bus.out_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .push     (push),
        .pop      (pop)
    );

    assign drop = bus.in_valid && !push;

    always_comb begin
        overflow_d = overflow_q;
        lo8_err_d  = lo8_err_q;
        drop_cnt_d = drop_cnt_q;
        tag_cnt_d  = tag_cnt_q;
        // clear wins over any event arriving in the same cycle.
        if (clear) begin
            overflow_d = 1'b0;
            lo8_err_d  = 1'b0;
            drop_cnt_d = '0;
            tag_cnt_d  = '0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
            end
            drop_cnt_d = sat_inc(drop_cnt_q, drop);
            tag_cnt_d  = sat_inc(tag_cnt_q, push && bus.tag);
            if (push && (bus.lo8 != bus.data[JIT_VEC_LO_W-1:0])) begin
                lo8_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            overflow_q <= 1'b0;
            lo8_err_q  <= 1'b0;
            drop_cnt_q <= '0;
            tag_cnt_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            lo8_err_q  <= lo8_err_d;
            drop_cnt_q <= drop_cnt_d;
            tag_cnt_q  <= tag_cnt_d;
        end
    end

`ifdef JIT_VEC_SINK_CKSUM_EN
    logic [JIT_VEC_DATA_W-1:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (clear) begin
            cksum_d = '0;
        end else if (push) begin
            cksum_d = cksum_q ^ bus.data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`endif

    assign bus.out_valid = rd_valid;
    assign bus.out_tag   = rd_data.tag;
    assign bus.out_data  = rd_data.data;
    assign bus.out_lo8   = rd_data.lo8;

    assign overflow = overflow_q;
    assign lo8_err  = lo8_err_q;
    assign drop_cnt = drop_cnt_q;
    assign tag_cnt  = tag_cnt_q;

endmodule

// File: tb/tb_jit_vec_sink.sv
// Bench for jit_vec_sink: directed scenarios plus random traffic against a queue model.
module tb_jit_vec_sink;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b0;
    logic             clear   = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] tag_cnt;
    logic             lo8_err;
`ifdef JIT_VEC_SINK_CKSUM_EN
    logic [15:0]      cksum;
`endif

    jit_vec_sink_if vif ();

    jit_vec_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (vif),
        .clear    (clear),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .tag_cnt  (tag_cnt),
        .lo8_err  (lo8_err)
`ifdef JIT_VEC_SINK_CKSUM_EN
        ,
        .cksum    (cksum)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {tag,data,lo8} plus plain statistics.
    logic [24:0] mq[$];
    int          m_drop;
    int          m_tag;
    bit          m_ovf;
    bit          m_lerr;
    logic [15:0] m_ck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drop = 0;
        m_tag  = 0;
        m_ovf  = 0;
        m_lerr = 0;
        m_ck   = '0;
    endtask

    task automatic compare_all(input string pfx);
        logic [24:0] head;
        head = (mq.size() > 0) ? mq[0] : 25'd0;
        check_val({pfx, "_count"},    32'(count), 32'(mq.size()));
        check_val({pfx, "_valid"},    32'(vif.out_valid), 32'(mq.size() > 0));
        check_val({pfx, "_tag"},      32'(vif.out_tag), 32'(head[24]));
        check_val({pfx, "_data"},     32'(vif.out_data), 32'(head[23:8]));
        check_val({pfx, "_lo8"},      32'(vif.out_lo8), 32'(head[7:0]));
        check_val({pfx, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check_val({pfx, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
        check_val({pfx, "_tag_cnt"},  32'(tag_cnt), 32'(m_tag));
        check_val({pfx, "_lo8_err"},  32'(lo8_err), 32'(m_lerr));
`ifdef JIT_VEC_SINK_CKSUM_EN
        check_val({pfx, "_cksum"},    32'(cksum), 32'(m_ck));
`endif
    endtask

    // Called at a falling edge; applies one cycle of stimulus and re-checks.
    task automatic cycle(input bit iv, input bit tg, input logic [15:0] d, input logic [7:0] l,
                         input bit rdy, input bit clr, input string pfx);
        bit popped;
        bit pushed;
        vif.in_valid  = iv;
        vif.tag       = tg;
        vif.data      = d;
        vif.lo8       = l;
        vif.out_ready = rdy;
        clear         = clr;

        popped = (mq.size() > 0) && rdy;
        pushed = iv && ((mq.size() < DEPTH) || popped);
        if (popped) void'(mq.pop_front());
        if (pushed) mq.push_back({tg, d, l});
        if (clr) begin
            m_drop = 0;
            m_tag  = 0;
            m_ovf  = 0;
            m_lerr = 0;
            m_ck   = '0;
        end else begin
            if (pushed) begin
                if (tg && m_tag < CMAX) m_tag++;
                if (l != d[7:0]) m_lerr = 1;
                m_ck = m_ck ^ d;
            end
            if (iv && !pushed) begin
                m_ovf = 1;
                if (m_drop < CMAX) m_drop++;
            end
        end

        @(posedge sys_clk);
        @(negedge sys_clk);
        compare_all(pfx);
    endtask

    task automatic idle(input string pfx);
        cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, pfx);
    endtask

    task automatic apply_reset();
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        compare_all("rst");
        sys_rst = 1'b1;
    endtask

    initial begin
        vif.in_valid  = 1'b0;
        vif.tag       = 1'b0;
        vif.data      = '0;
        vif.lo8       = '0;
        vif.out_ready = 1'b0;
        model_reset();

        // Reset state, then a single push becomes visible one edge later.
        apply_reset();
        cycle(1'b1, 1'b0, 16'h1234, 8'h34, 1'b0, 1'b0, "first");
        check_val("first_data_const", 32'(vif.out_data), 32'h1234);
        check_val("first_lo8_const",  32'(vif.out_lo8), 32'h34);
        check_val("first_count_const", 32'(count), 32'd1);

        // Six pushes without ready: two drops, then ordered drain.
        apply_reset();
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'(i), 16'h0100 + 16'(i), 8'(i), 1'b0, 1'b0, "fill6");
        check_val("fill6_count_const", 32'(count), 32'd4);
        check_val("fill6_drop_const",  32'(drop_cnt), 32'd2);
        check_val("fill6_ovf_const",   32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("drain_order", 32'(vif.out_data), 32'h0100 + 32'(i));
            cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "drain");
        end
        check_val("drain_empty", 32'(vif.out_valid), 32'd0);

        // Full FIFO streaming with push and pop every cycle.
        apply_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 16'h2000 + 16'(i), 8'(i), 1'b0, 1'b0, "full_fill");
        for (int i = 0; i < 10; i++) begin
            check_val("stream_order", 32'(vif.out_data), 32'h2000 + 32'(i));
            cycle(1'b1, 1'b0, 16'h2004 + 16'(i), 8'(4 + i), 1'b1, 1'b0, "stream");
        end
        check_val("stream_count_const", 32'(count), 32'd4);
        check_val("stream_drop_const",  32'(drop_cnt), 32'd0);

        // Tag count, lo8 mismatch, then clear leaves the entry in place.
        apply_reset();
        cycle(1'b1, 1'b1, 16'h00FF, 8'h0F, 1'b0, 1'b0, "tagerr");
        check_val("tagerr_tag_const", 32'(tag_cnt), 32'd1);
        check_val("tagerr_err_const", 32'(lo8_err), 32'd1);
        cycle(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b1, "clear");
        check_val("clear_tag_const",   32'(tag_cnt), 32'd0);
        check_val("clear_err_const",   32'(lo8_err), 32'd0);
        check_val("clear_count_const", 32'(count), 32'd1);
        check_val("clear_data_const",  32'(vif.out_data), 32'h00FF);
        // A drop in the same cycle as clear is not counted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h5555, 8'h55, 1'b0, 1'b0, "cfill");
        cycle(1'b1, 1'b1, 16'h6666, 8'h00, 1'b0, 1'b1, "clear_drop");
        check_val("clear_drop_const", 32'(drop_cnt), 32'd0);

        // Drop counter saturation.
        apply_reset();
        for (int i = 0; i < DEPTH + CMAX + 5; i++)
            cycle(1'b1, 1'b1, 16'(i), 8'(i), 1'b0, 1'b0, "sat");
        check_val("sat_drop_const", 32'(drop_cnt), 32'(CMAX));

        // Asynchronous reset between clock edges with three entries buffered.
        apply_reset();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 16'h3000 + 16'(i), 8'h00, 1'b0, 1'b0, "pre_arst");
        check_val("pre_arst_count", 32'(count), 32'd3);
        #2;
        sys_rst = 1'b0;
        #1;
        check_val("arst_count", 32'(count), 32'd0);
        check_val("arst_valid", 32'(vif.out_valid), 32'd0);
        check_val("arst_data",  32'(vif.out_data), 32'd0);
        check_val("arst_tag",   32'(tag_cnt), 32'd0);
        check_val("arst_err",   32'(lo8_err), 32'd0);
        model_reset();
        @(negedge sys_clk);
        compare_all("arst_hold");
        sys_rst = 1'b1;

`ifdef JIT_VEC_SINK_CKSUM_EN
        apply_reset();
        cycle(1'b1, 1'b0, 16'hA5A5, 8'hA5, 1'b0, 1'b0, "ck1");
        cycle(1'b1, 1'b0, 16'h0F0F, 8'h0F, 1'b0, 1'b0, "ck2");
        check_val("cksum_const", 32'(cksum), 32'hAAAA);
`endif

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            logic [7:0]  l;
            d = 16'($urandom);
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom) : d[7:0];
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), d, l,
                  1'($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
